// File: rtl/frogger_level_sequencer.sv
// Frogger game-flow controller: level/lives tracking, clear pulses and per-level scroll tick.
// Optional pause input and paused state enabled by defining CC_LEVELSEQ_PAUSE_EN.
module frogger_level_sequencer #(
  parameter int unsigned LEVELS     = 4,
  parameter int unsigned LIVES      = 3,
  parameter logic [23:0] BASE_DIV   = 24'd12_500_000,
  parameter logic [23:0] STEP_DIV   = 24'd2_500_000,
  parameter logic [23:0] MIN_DIV    = 24'd2_500_000,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic       CC_LEVELSEQ_CLOCK_50,
  input  logic       CC_LEVELSEQ_RESET_InLow,
  input  logic       CC_LEVELSEQ_Start_InLow,
  input  logic       CC_LEVELSEQ_WinL_InHigh,
  input  logic       CC_LEVELSEQ_Crash_InHigh,
`ifdef CC_LEVELSEQ_PAUSE_EN
  input  logic       CC_LEVELSEQ_Pause_InLow,
`endif
  output logic       CC_LEVELSEQ_Clear_OutHigh,
  output logic       CC_LEVELSEQ_Tick_OutHigh,
  output logic [1:0] CC_LEVELSEQ_Level_Out,
  output logic [1:0] CC_LEVELSEQ_Lives_Out,
  output logic [2:0] CC_LEVELSEQ_State_Out,
  output logic       CC_LEVELSEQ_GameOver_OutHigh,
  output logic       CC_LEVELSEQ_GameWon_OutHigh
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_WINH   = 3'd3;
  localparam logic [2:0] ST_LOSEH  = 3'd4;
  localparam logic [2:0] ST_WON    = 3'd5;
  localparam logic [2:0] ST_LOST   = 3'd6;
  localparam logic [2:0] ST_PAUSED = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [1:0]        lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              start_prev_q;
  logic              restart_q, restart_d;
  logic              clear_q, clear_d;
  logic              tick_q, tick_d;
  logic              won_q, won_d;
  logic              lost_q, lost_d;
  logic [2:0]        state_out_q, state_out_d;
  logic              start_fall;
  logic              cnt_zero;
  logic              cnt_run;

  // Scroll period for a level: BASE - level*STEP, floored at MIN; underflow saturates to MIN.
  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] lvl);
    logic [CNT_W-1:0] prod;
    logic [CNT_W-1:0] diff;
    prod = CNT_W'(lvl) * STEP_DIV;
    diff = BASE_DIV - prod;
    if ((prod > BASE_DIV) || (diff < MIN_DIV)) return MIN_DIV;
    return diff;
  endfunction

  assign start_fall = start_prev_q & ~CC_LEVELSEQ_Start_InLow;
  assign cnt_zero   = (cnt_q == '0);

`ifdef CC_LEVELSEQ_PAUSE_EN
  logic pause_prev_q;
  logic paused_q, paused_d;
  logic pause_fall;

  assign pause_fall = pause_prev_q & ~CC_LEVELSEQ_Pause_InLow;
  assign cnt_run    = ~paused_q;

  always_ff @(posedge CC_LEVELSEQ_CLOCK_50 or negedge CC_LEVELSEQ_RESET_InLow) begin
    if (!CC_LEVELSEQ_RESET_InLow) begin
      pause_prev_q <= 1'b1;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= CC_LEVELSEQ_Pause_InLow;
      paused_q     <= paused_d;
    end
  end
`else
  assign cnt_run = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    restart_d = 1'b0;
`ifdef CC_LEVELSEQ_PAUSE_EN
    paused_d  = paused_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!CC_LEVELSEQ_Start_InLow || restart_q) begin
          state_d = ST_INIT;
          level_d = '0;
          lives_d = 2'(LIVES);
        end
      end
      ST_INIT: begin
        state_d = ST_PLAY;
        cnt_d   = div_of(level_q);
      end
      ST_PLAY: begin
        if (cnt_run) begin
          cnt_d = cnt_zero ? div_of(level_q) : cnt_q - CNT_W'(1);
          if (CC_LEVELSEQ_WinL_InHigh) begin
            state_d = ST_WINH;
            hold_d  = '0;
          end else if (CC_LEVELSEQ_Crash_InHigh) begin
            state_d = ST_LOSEH;
            hold_d  = '0;
            if (lives_q != '0) lives_d = lives_q - 2'd1;
          end
        end
`ifdef CC_LEVELSEQ_PAUSE_EN
        if (pause_fall) paused_d = ~paused_q;
`endif
      end
      ST_WINH, ST_LOSEH: begin
        // Counter keeps running; its wraps count off the hold period.
        cnt_d = cnt_zero ? div_of(level_q) : cnt_q - CNT_W'(1);
        if (cnt_zero) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            if (state_q == ST_WINH) begin
              if (level_q == 2'(LEVELS - 1)) begin
                state_d = ST_WON;
              end else begin
                state_d = ST_INIT;
                level_d = level_q + 2'd1;
              end
            end else begin
              state_d = (lives_q == '0) ? ST_LOST : ST_INIT;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_WON, ST_LOST: begin
        if (start_fall) begin
          state_d   = ST_IDLE;
          restart_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CC_LEVELSEQ_PAUSE_EN
    if (state_d != ST_PLAY) paused_d = 1'b0;
`endif
    clear_d     = (state_d == ST_INIT);
    tick_d      = (state_q == ST_PLAY) && cnt_run && cnt_zero && (state_d == ST_PLAY);
    won_d       = (state_d == ST_WON);
    lost_d      = (state_d == ST_LOST);
    state_out_d = state_d;
`ifdef CC_LEVELSEQ_PAUSE_EN
    if (paused_d) state_out_d = ST_PAUSED;
`endif
  end

  always_ff @(posedge CC_LEVELSEQ_CLOCK_50 or negedge CC_LEVELSEQ_RESET_InLow) begin
    if (!CC_LEVELSEQ_RESET_InLow) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      lives_q      <= 2'(LIVES);
      cnt_q        <= '0;
      hold_q       <= '0;
      start_prev_q <= 1'b1;
      restart_q    <= 1'b0;
      clear_q      <= 1'b0;
      tick_q       <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      state_out_q  <= ST_IDLE;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      start_prev_q <= CC_LEVELSEQ_Start_InLow;
      restart_q    <= restart_d;
      clear_q      <= clear_d;
      tick_q       <= tick_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
      state_out_q  <= state_out_d;
    end
  end

  assign CC_LEVELSEQ_Clear_OutHigh    = clear_q;
  assign CC_LEVELSEQ_Tick_OutHigh     = tick_q;
  assign CC_LEVELSEQ_Level_Out        = level_q;
  assign CC_LEVELSEQ_Lives_Out        = lives_q;
  assign CC_LEVELSEQ_State_Out        = state_out_q;
  assign CC_LEVELSEQ_GameOver_OutHigh = lost_q;
  assign CC_LEVELSEQ_GameWon_OutHigh  = won_q;

endmodule
